hex_input_editor: RTL

HEX_INPUT_EDITOR -- requirements
Module: hex_input_editor

---
 rtl/hex_input_editor_pkg.sv | 23 ++
 rtl/hex_input_editor_btn_debounce.sv | 96 +++++++++
 rtl/hex_input_editor.sv | 118 +++++++++++
 3 files changed

// File: rtl/hex_input_editor_pkg.sv
// Shared constants and types for the hex input editor: button lanes,
// increment modes and the per-cycle digit operation.
package hex_input_editor_pkg;

  // Bit positions of the four raw buttons.
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_INC = 2;
  localparam int BTN_DEC = 3;

  // Increment modes: wrap inside the selected nibble, or carry/borrow
  // through the whole register.
  localparam int CARRY_NIBBLE = 0;
  localparam int CARRY_WORD   = 1;

  // Digit operation resolved from the increment/decrement events.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } digit_op_e;

endpackage

// File: rtl/hex_input_editor_btn_debounce.sv
// One button lane: 2-flop synchroniser, counting debouncer, press pulse and
// optional auto-repeat. After reset the lane stays disarmed until it has seen
// a debounced low, so a button held through reset never produces an event.
module btn_debounce #(
  parameter int DB_CYC  = 16,
  parameter int REP_DLY = 0,
  parameter int REP_PER = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam int DBW   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int RMAX  = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW    = $clog2(RMAX + 1);

  logic [1:0]     sync_q;
  logic           level_q, level_d;
  logic           arm_q, arm_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           press_q, press_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic           rep_first_q, rep_first_d;

  // Debounce, arming, press detection and repeat timing.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    level_d     = level_q;
    arm_d       = arm_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;

    if (!arm_q) begin
      // Wait for DB_CYC consecutive low samples before accepting presses.
      if (sync_q[1]) begin
        cnt_d = '0;
      end else if (cnt_q == DBW'(DB_CYC - 1)) begin
        arm_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DBW'(1);
      end
    end else if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DBW'(DB_CYC - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      press_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + DBW'(1);
    end

    if (REP_DLY > 0) begin
      // Repeat only while the level stays high across this edge.
      if (!(level_q && level_d)) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end else if (rep_cnt_q == (rep_first_q ? RW'(REP_DLY - 1) : RW'(REP_PER - 1))) begin
        press_d     = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  // Lane state registers, all returned to the released state on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      arm_q       <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q      <= {sync_q[0], raw_i};
      level_q     <= level_d;
      arm_q       <= arm_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hex_input_editor.sv
// Hex register editor: four debounced buttons move a digit cursor and
// increment/decrement the selected digit of one of NCH registers, with a
// parallel load path that takes priority over button edits.
module hex_input_editor
  import hex_input_editor_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int W       = 32,
  parameter int DB_CYC  = 16,
  parameter int REP_DLY = 0,
  parameter int REP_PER = 1,
  parameter int CARRY   = CARRY_NIBBLE,
  parameter logic [NCH*W-1:0] INIT = {32'h12345678, 32'h87654321},
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int ND = W / 4,
  localparam int DW = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn,
  input  logic             edit_en,
  input  logic [CW-1:0]    ch_sel,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  output logic [NCH*W-1:0] data,
  output logic [DW-1:0]    cursor,
  output logic [ND-1:0]    blink,
  output logic             upd
);

  logic [3:0]              ev;
  logic                    ch_ok;
  digit_op_e               op;
  logic [NCH-1:0][W-1:0]   data_q, data_d;
  logic [DW-1:0]           cursor_q, cursor_d;
  logic                    upd_q, upd_d;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    // Only the digit buttons auto-repeat; cursor buttons never do.
    btn_debounce #(
      .DB_CYC (DB_CYC),
      .REP_DLY((i == BTN_INC || i == BTN_DEC) ? REP_DLY : 0),
      .REP_PER(REP_PER)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (btn[i]),
      .press_o(ev[i])
    );
  end

  assign ch_ok = (int'(ch_sel) < NCH);

  // Apply one +/-1 step at digit cur, either nibble-local or carrying through the word.
  function automatic logic [W-1:0] step_word(input logic [W-1:0] word,
                                              input logic [DW-1:0] cur,
                                              input logic dec);
    logic [W-1:0] w;
    logic [W-1:0] unit;
    logic [3:0]   nib;
    w    = word;
    unit = W'(1) << {cur, 2'b00};
    nib  = word[{cur, 2'b00} +: 4];
    if (CARRY == CARRY_WORD) begin
      w = dec ? (word - unit) : (word + unit);
    end else begin
      nib = dec ? (nib - 4'd1) : (nib + 4'd1);
      w[{cur, 2'b00} +: 4] = nib;
    end
    return w;
  endfunction

  // Resolve events into cursor moves and register edits; load wins over edits.
  always_comb begin
    op       = OP_NONE;
    data_d   = data_q;
    cursor_d = cursor_q;

    if (edit_en && ch_ok) begin
      if (ev[BTN_INC] && !ev[BTN_DEC])      op = OP_INC;
      else if (ev[BTN_DEC] && !ev[BTN_INC]) op = OP_DEC;
    end

    // Edits use the cursor as it stands before any move in this cycle.
    for (int k = 0; k < NCH; k++) begin
      if (int'(ch_sel) == k) begin
        if (load)                data_d[k] = load_data;
        else if (op != OP_NONE)  data_d[k] = step_word(data_q[k], cursor_q, op == OP_DEC);
      end
    end

    if (edit_en && (ev[BTN_UP] != ev[BTN_DN])) begin
      if (ev[BTN_UP]) cursor_d = (cursor_q == DW'(ND - 1)) ? '0 : cursor_q + DW'(1);
      else            cursor_d = (cursor_q == '0) ? DW'(ND - 1) : cursor_q - DW'(1);
    end

    upd_d = (data_d != data_q);
  end

  // Register file, cursor and update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= INIT;
      cursor_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      cursor_q <= cursor_d;
      upd_q    <= upd_d;
    end
  end

  assign data   = data_q;
  assign cursor = cursor_q;
  assign upd    = upd_q;
  assign blink  = edit_en ? (ND'(1) << cursor_q) : '0;

endmodule
